ps2_keyboard_rx: RTL and testbench

- Receives PS/2 keyboard frames on the raw ps2clk/ps2data pins and decodes scan-code set 2 make/break/extended sequences.
- Presents each key press as an 8-bit make code plus a one-cycle strobe.
- Sits directly upstream of the VGA sync/rectangle generator and drives its scancode/flagkey inputs. Arrow codes are 8'h75, 8'h72, 8'h6b and 8'h74.

---
 rtl/ps2_keyboard_rx_pkg.sv | 36 +++
 rtl/ps2_keyboard_rx_if.sv | 28 ++
 rtl/ps2_keyboard_rx_pin_filter.sv | 61 ++++++
 rtl/ps2_keyboard_rx.sv | 162 ++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_keyboard_rx_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver.
// Also holds the arrow-key make codes that the VGA rectangle block uses.
package ps2_pkg;

    // Frame receiver states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Scan-code set 2 prefix bytes
    localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
    localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

    // Arrow-key make codes, also used by the VGA block
    localparam logic [7:0] UP    = 8'h75;
    localparam logic [7:0] DOWN  = 8'h72;
    localparam logic [7:0] LEFT  = 8'h6b;
    localparam logic [7:0] RIGHT = 8'h74;

    // Internal observation bundle: frame state plus the filtered fall pulse
    typedef struct packed {
        ps2_state_e state;
        logic [2:0] bitcnt;
        logic       parity;
        logic       fall;
    } ps2_dbg_t;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_key_if: decoded key event bus from the PS/2 receiver to the VGA block.
//
// Handshake: flagkey is a valid-only strobe with no ready/backpressure. It is
// high for exactly one clk cycle and scancode/extended are valid in that same
// cycle; both hold their value until the next strobe. frame_err is an
// independent one-cycle pulse and is never high together with flagkey.
interface ps2_key_if;
    logic [7:0] scancode;
    logic       flagkey;
    logic       extended;
    logic       frame_err;

    // Receiver side drives the bus
    modport master (
        output scancode,
        output flagkey,
        output extended,
        output frame_err
    );

    // Consumer side (VGA block, testbench)
    modport slave (
        input scancode,
        input flagkey,
        input extended,
        input frame_err
    );
endinterface

// File: rtl/ps2_keyboard_rx_pin_filter.sv
// ps2_pin_filter: synchronises the raw ps2clk/ps2data pins, debounces the
// clock with a FILTER_LEN run-length filter and emits a one-cycle pulse on
// each filtered 1->0 clock transition. Data is only synchronised; it is
// sampled by the frame logic when the fall pulse is high.
module ps2_pin_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2clk,
    input  logic ps2data,
    output logic fall,
    output logic data_sync
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_s;
    logic                   filt;
    logic [CW-1:0]          cnt;

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign data_sync = dat_sync[SYNC_STAGES-1];

    // Synchroniser chains; preset high because an idle PS/2 line is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2data};
        end
    end

    // Run-length filter: flip the filtered level after FILTER_LEN samples
    // that all differ from it; any agreeing sample restarts the run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                filt <= clk_s;
                cnt  <= '0;
                fall <= filt & ~clk_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver with scan-code set 2 decoding.
// Turns raw ps2clk/ps2data into one strobe per key press (make code plus
// E0-extended flag); break sequences are swallowed.
// Optional build macro PS2_PARITY_CHECK_EN: when defined, a bad odd-parity
// bit discards the byte like a stop-bit error; otherwise parity is ignored.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     ps2clk,
    input  logic     ps2data,
    ps2_key_if.master key,
    output ps2_dbg_t dbg
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic        fall;
    logic        data;

    ps2_state_e  state;
    logic [2:0]  bitcnt;
    logic [7:0]  shreg;
    logic        parity_bit;
    logic [TW-1:0] tcnt;
    logic        byte_done;
    logic [7:0]  byte_q;
    logic        frame_err_q;
    logic        stop_ok;

    logic [7:0]  scancode_q;
    logic        flagkey_q;
    logic        extended_q;
    logic        ext_pending;
    logic        brk_pending;

    ps2_pin_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_pin_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2clk    (ps2clk),
        .ps2data   (ps2data),
        .fall      (fall),
        .data_sync (data)
    );

`ifdef PS2_PARITY_CHECK_EN
    assign stop_ok = data & odd_parity_ok(shreg, parity_bit);
`else
    assign stop_ok = data;
`endif

    // Frame FSM: steps on filtered clock falls, aborts stalled frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bitcnt      <= '0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            tcnt        <= '0;
            byte_done   <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            byte_done   <= 1'b0;
            frame_err_q <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        // A high start bit is line noise, not an error
                        if (!data) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {data, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= data;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (stop_ok) begin
                            byte_done <= 1'b1;
                            byte_q    <= shreg;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt == T_MAX) begin
                // Keyboard stopped mid-frame: drop the partial byte
                state       <= IDLE;
                tcnt        <= '0;
                frame_err_q <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Set-2 decoder: track E0/F0 prefixes, strobe only on make codes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scancode_q  <= '0;
            flagkey_q   <= 1'b0;
            extended_q  <= 1'b0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
        end else begin
            flagkey_q <= 1'b0;
            if (frame_err_q) begin
                // A lost byte may have been part of a prefix sequence
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
            end else if (byte_done) begin
                if (byte_q == PS2_EXT_CODE) begin
                    ext_pending <= 1'b1;
                end else if (byte_q == PS2_BRK_CODE) begin
                    brk_pending <= 1'b1;
                end else if (brk_pending) begin
                    ext_pending <= 1'b0;
                    brk_pending <= 1'b0;
                end else begin
                    scancode_q  <= byte_q;
                    extended_q  <= ext_pending;
                    flagkey_q   <= 1'b1;
                    ext_pending <= 1'b0;
                end
            end
        end
    end

    assign key.scancode  = scancode_q;
    assign key.flagkey   = flagkey_q;
    assign key.extended  = extended_q;
    assign key.frame_err = frame_err_q;

    assign dbg.state  = state;
    assign dbg.bitcnt = bitcnt;
    assign dbg.parity = parity_bit;
    assign dbg.fall   = fall;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Testbench for ps2_keyboard_rx: drives PS/2 frames bit by bit on the raw
// pins and compares decoded key events against a byte-level model of the
// scan-code set 2 rules.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2clk = 1'b1;
    logic ps2data = 1'b1;
    ps2_dbg_t dbg;

    always #20 clk = ~clk;  // 25 MHz

    ps2_key_if key_bus ();

    ps2_keyboard_rx #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (5000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2clk  (ps2clk),
        .ps2data (ps2data),
        .key     (key_bus.master),
        .dbg     (dbg)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [8:0] exp_q[$];   // {extended, scancode} per expected strobe
    logic [8:0] got_q[$];
    int         lat_q[$];
    int         exp_err = 0;
    int         err_seen = 0;
    int         coll = 0;
    bit         m_ext = 0;
    bit         m_brk = 0;

    // Frame-level outcome then byte-level set-2 decoding
    function automatic void model_frame(input logic [7:0] b, input bit bad_par, input bit stop_val);
        if (!stop_val || (PAR_CHK && bad_par)) begin
            exp_err++;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (m_brk) begin
            m_ext = 0;
            m_brk = 0;
        end else begin
            exp_q.push_back({m_ext, b});
            m_ext = 0;
        end
    endfunction

    // ---------------- monitor ----------------
    int cyc = 0;
    int fall_cyc = 0;
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (dbg.fall) fall_cyc = cyc;
            if (key_bus.flagkey) begin
                got_q.push_back({key_bus.extended, key_bus.scancode});
                lat_q.push_back(cyc - fall_cyc);
            end
            if (key_bus.frame_err) err_seen++;
            if (key_bus.flagkey && key_bus.frame_err) coll++;
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit stop_val);
        logic p;
        p = (~^b) ^ bad_par;
        return {stop_val, p, b, 1'b0};
    endfunction

    // Send the first n bits of a frame; glitch adds a 5-cycle low pulse on
    // ps2clk in every high phase
    task automatic send_raw(input logic [10:0] bits, input int n, input int half, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2data = bits[i];
            if (glitch) begin
                repeat (4) @(negedge clk);
                ps2clk = 1'b0;
                repeat (5) @(negedge clk);
                ps2clk = 1'b1;
                repeat (half - 9) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            ps2clk = 1'b0;
            repeat (half) @(negedge clk);
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_val, input int half);
        send_raw(frame_bits(b, bad_par, stop_val), 11, half, 1'b0);
        model_frame(b, bad_par, stop_val);
        repeat (4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (key_bus.scancode !== 8'h00) begin errors++; $display("FAIL reset_scancode got=%h exp=00", key_bus.scancode); end
        checks++; if (key_bus.flagkey !== 1'b0) begin errors++; $display("FAIL reset_flagkey got=%b exp=0", key_bus.flagkey); end
        checks++; if (key_bus.extended !== 1'b0) begin errors++; $display("FAIL reset_extended got=%b exp=0", key_bus.extended); end
        checks++; if (key_bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", key_bus.frame_err); end
        checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg.state, IDLE); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_valid_frame();
        logic [8:0] g;
        int e0;
        e0 = err_seen;
        send_frame(UP, 1'b0, 1'b1, 1000);  // 80 us PS/2 clock
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL valid_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++; if (g !== {1'b0, UP}) begin errors++; $display("FAIL valid_code got=%h exp=%h", g, {1'b0, UP}); end
            checks++; if (lat_q[0] != 2) begin errors++; $display("FAIL valid_latency got=%0d exp=2", lat_q[0]); end
        end
        checks++; if (err_seen - e0 != 0) begin errors++; $display("FAIL valid_err got=%0d exp=0", err_seen - e0); end
        repeat (20) @(negedge clk);
        checks++; if (key_bus.scancode !== UP) begin errors++; $display("FAIL valid_hold got=%h exp=%h", key_bus.scancode, UP); end
        got_q.delete(); lat_q.delete(); exp_q.delete();
    endtask

    task automatic test_ext_sequence();
        logic [7:0] seq[5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        logic [8:0] g;
        logic [8:0] e;
        for (int i = 0; i < 5; i++) send_frame(seq[i], 1'b0, 1'b1, 20);
        checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL ext_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL ext_code got=%h exp=%h", g, e); end
        end
        checks++; if (key_bus.extended !== 1'b1) begin errors++; $display("FAIL ext_hold got=%b exp=1", key_bus.extended); end
        checks++; if (key_bus.scancode !== 8'h75) begin errors++; $display("FAIL ext_scancode got=%h exp=75", key_bus.scancode); end
        got_q.delete(); lat_q.delete(); exp_q.delete();
    endtask

    task automatic test_break_sequence();
        logic [7:0] seq[4] = '{8'h6b, 8'hF0, 8'h6b, 8'h74};
        logic [8:0] g;
        logic [8:0] e;
        for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b0, 1'b1, 16);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL brk_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL brk_code got=%h exp=%h", g, e); end
        end
        checks++; if (key_bus.scancode !== 8'h74) begin errors++; $display("FAIL brk_final got=%h exp=74", key_bus.scancode); end
        got_q.delete(); lat_q.delete(); exp_q.delete();
    endtask

    task automatic test_errors();
        logic [8:0] g;
        logic [8:0] e;
        int e0;
        e0 = exp_err;
        err_seen = 0; exp_err = 0;
        send_frame(8'hE0, 1'b0, 1'b1, 20);          // leaves extension pending
        send_frame(8'h75, 1'b0, 1'b0, 20);          // bad stop bit
        send_raw(frame_bits(8'h6b, 1'b0, 1'b1), 5, 20, 1'b0);  // start + 4 bits
        repeat (5200) @(negedge clk);
        model_frame(8'h00, 1'b0, 1'b0);             // timeout behaves as a lost frame
        checks++; if (err_seen != exp_err) begin errors++; $display("FAIL err_pulses got=%0d exp=%0d", err_seen, exp_err); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL err_noflag got=%0d exp=0", got_q.size()); end
        send_frame(DOWN, 1'b0, 1'b1, 20);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL err_recover_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL err_recover_code got=%h exp=%h", g, e); end
        end
        exp_err = e0 + exp_err;
        got_q.delete(); lat_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch_reset();
        logic [8:0] g;
        logic [8:0] e;
        send_raw(frame_bits(LEFT, 1'b0, 1'b1), 11, 30, 1'b1);
        model_frame(LEFT, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        // partial frame: start + 3 data bits, then reset
        send_raw(frame_bits(8'h55, 1'b0, 1'b1), 4, 30, 1'b1);
        reset = 1'b1;
        #1;
        checks++; if (key_bus.scancode !== 8'h00) begin errors++; $display("FAIL rst_mid_scancode got=%h exp=00", key_bus.scancode); end
        checks++; if (key_bus.extended !== 1'b0 || key_bus.flagkey !== 1'b0 || key_bus.frame_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags got=%b%b%b exp=000", key_bus.extended, key_bus.flagkey, key_bus.frame_err);
        end
        checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL rst_mid_state got=%0d exp=%0d", dbg.state, IDLE); end
        m_ext = 0; m_brk = 0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_raw(frame_bits(RIGHT, 1'b0, 1'b1), 11, 30, 1'b1);
        model_frame(RIGHT, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL glitch_code got=%h exp=%h", g, e); end
        end
        got_q.delete(); lat_q.delete(); exp_q.delete();
    endtask

    task automatic test_parity();
        int e0;
        int x0;
        e0 = err_seen; x0 = exp_err;
        send_frame(8'h75, 1'b1, 1'b1, 20);
        checks++; if (err_seen - e0 != exp_err - x0) begin errors++; $display("FAIL parity_err got=%0d exp=%0d", err_seen - e0, exp_err - x0); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL parity_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        if (!PAR_CHK) begin
            checks++; if (key_bus.scancode !== 8'h75) begin errors++; $display("FAIL parity_scancode got=%h exp=75", key_bus.scancode); end
        end
        got_q.delete(); lat_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [8:0] g;
        logic [8:0] e;
        int r;
        int e0;
        int x0;
        e0 = err_seen; x0 = exp_err;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hE0;
            else if (r == 2) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0), $urandom_range(14, 30));
        end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL rand_code got=%h exp=%h", g, e); end
        end
        foreach (lat_q[i]) begin
            checks++; if (lat_q[i] != 2) begin errors++; $display("FAIL rand_latency got=%0d exp=2", lat_q[i]); end
        end
        checks++; if (err_seen - e0 != exp_err - x0) begin errors++; $display("FAIL rand_err got=%0d exp=%0d", err_seen - e0, exp_err - x0); end
        got_q.delete(); lat_q.delete(); exp_q.delete();
    endtask

    task automatic test_exclusive();
        checks++; if (coll != 0) begin errors++; $display("FAIL flag_err_overlap got=%0d exp=0", coll); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_valid_frame();
        test_ext_sequence();
        test_break_sequence();
        test_errors();
        test_glitch_reset();
        test_parity();
        test_random();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the whole run is a few ms of simulated time
    initial begin
        #20ms;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
